// File: rtl/serial_router_16x16.sv
// ---------------------------------------------------------------------------
// serial_router_16x16
//
// 16x16 bit-serial packet switch. Every input port carries packets made of a
// 4-bit destination address (LSB first), optional padding cycles and a
// variable-length payload, all framed by an active-low frame signal. Once the
// address is complete the input is connected through a crossbar to the
// addressed output, and the output registers mirror the source with exactly
// one clock of latency until the source frame ends. Inputs that lose
// arbitration, or that address an output already in use, are dropped and
// signal this on busy_n.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   din       in   [15:0] serial data per input
//   frame_n   in   [15:0] active-low frame per input
//   valid_n   in   [15:0] active-low payload-bit qualifier per input
//   dout      out  [15:0] serial data per output
//   valido_n  out  [15:0] active-low payload-bit qualifier per output
//   frameo_n  out  [15:0] active-low frame per output
//   busy_n    out  [15:0] low while the matching input's packet is dropped
//
// Build option:
//   ROUTER_RR_ARB_EN  when defined, each output arbitrates simultaneous
//                     requests round-robin (per-output pointer, reset to 0,
//                     moved to winner+1 on every grant). When undefined the
//                     lowest input index wins and no pointer logic exists.
// ---------------------------------------------------------------------------
module serial_router_16x16 #(
  parameter int NPORTS    = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NPORTS-1:0] din,
  input  logic [NPORTS-1:0] frame_n,
  input  logic [NPORTS-1:0] valid_n,
  output logic [NPORTS-1:0] dout,
  output logic [NPORTS-1:0] valido_n,
  output logic [NPORTS-1:0] frameo_n,
  output logic [NPORTS-1:0] busy_n
);

  localparam int CNT_BITS = $clog2(ADDR_BITS);

  typedef enum logic [2:0] {IDLE, ADDR, XFER, DROP, WAITEND} inState_t;

  inState_t                 state     [NPORTS];
  inState_t                 stateNext [NPORTS];
  logic [ADDR_BITS-2:0]     addrLow   [NPORTS];  // address bits 0..2; bit3 is taken live from din
  logic [CNT_BITS-1:0]      bitCnt    [NPORTS];  // index of the address bit sampled next
  logic                     started;             // low only for the first edge after reset

  logic [NPORTS-1:0]        outLocked;
  logic [ADDR_BITS-1:0]     outSrc    [NPORTS];

  logic [NPORTS-1:0]        reqValid;
  logic [ADDR_BITS-1:0]     reqDest   [NPORTS];
  logic [NPORTS-1:0]        grantIn;             // per input: won an output this edge
  logic [NPORTS-1:0]        grantOut;            // per output: granted this edge
  logic [ADDR_BITS-1:0]     grantSrc  [NPORTS];

`ifdef ROUTER_RR_ARB_EN
  logic [ADDR_BITS-1:0]     rrPtr     [NPORTS];
`endif

  // A request exists on the edge that samples address bit3 with the frame
  // still low; the destination combines the stored bits with the live bit.
  always_comb begin
    for (int s = 0; s < NPORTS; s++) begin
      reqValid[s] = (state[s] == ADDR) && (bitCnt[s] == CNT_BITS'(ADDR_BITS - 1)) && !frame_n[s];
      reqDest[s]  = {din[s], addrLow[s]};
    end
  end

  // Only free outputs arbitrate, so a locked output is never preempted.
  // NOTE: every signal driven here gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin : arbitrate
    logic                 found;
    logic [ADDR_BITS-1:0] idx;
    grantIn  = '0;
    grantOut = '0;
    found    = 1'b0;
    idx      = '0;
    for (int d = 0; d < NPORTS; d++) grantSrc[d] = '0;
    for (int d = 0; d < NPORTS; d++) begin
      found = 1'b0;
      if (!outLocked[d]) begin
        for (int k = 0; k < NPORTS; k++) begin
`ifdef ROUTER_RR_ARB_EN
          idx = rrPtr[d] + ADDR_BITS'(k);
`else
          idx = ADDR_BITS'(k);
`endif
          if (!found && reqValid[idx] && (reqDest[idx] == ADDR_BITS'(d))) begin
            found        = 1'b1;
            grantOut[d]  = 1'b1;
            grantSrc[d]  = idx;
            grantIn[idx] = 1'b1;
          end
        end
      end
    end
  end

  // Input FSM: state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      for (int s = 0; s < NPORTS; s++) state[s] <= IDLE;
    end else begin
      started <= 1'b1;
      for (int s = 0; s < NPORTS; s++) state[s] <= stateNext[s];
    end
  end

  // Input FSM: next-state logic. A frame still low on the first edge after
  // reset belongs to a packet cut by the reset, so it is waited out.
  always_comb begin
    for (int s = 0; s < NPORTS; s++) begin
      stateNext[s] = state[s];
      case (state[s])
        IDLE: begin
          if (!frame_n[s]) stateNext[s] = started ? ADDR : WAITEND;
        end
        ADDR: begin
          if (frame_n[s])
            stateNext[s] = IDLE;
          else if (bitCnt[s] == CNT_BITS'(ADDR_BITS - 1))
            stateNext[s] = grantIn[s] ? XFER : DROP;
        end
        XFER, DROP, WAITEND: begin
          if (frame_n[s]) stateNext[s] = IDLE;
        end
        default: stateNext[s] = IDLE;
      endcase
    end
  end

  // Input FSM: outputs.
  always_comb begin
    for (int s = 0; s < NPORTS; s++) busy_n[s] = (state[s] != DROP);
  end

  // Address shift-in, LSB first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NPORTS; s++) begin
        addrLow[s] <= '0;
        bitCnt[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NPORTS; s++) begin
        if (state[s] == IDLE) begin
          addrLow[s] <= (ADDR_BITS-1)'(din[s]);
          bitCnt[s]  <= CNT_BITS'(1);
        end else if (state[s] == ADDR) begin
          if (bitCnt[s] != CNT_BITS'(ADDR_BITS - 1)) addrLow[s][bitCnt[s]] <= din[s];
          bitCnt[s] <= bitCnt[s] + CNT_BITS'(1);
        end
      end
    end
  end

  // Crossbar: a locked output copies its source each edge, including the
  // edge that samples the source frame high, which is also where it unlocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outLocked <= '0;
      dout      <= '0;
      valido_n  <= '1;
      frameo_n  <= '1;
      for (int d = 0; d < NPORTS; d++) outSrc[d] <= '0;
    end else begin
      for (int d = 0; d < NPORTS; d++) begin
        if (outLocked[d]) begin
          dout[d]     <= din[outSrc[d]];
          valido_n[d] <= valid_n[outSrc[d]];
          frameo_n[d] <= frame_n[outSrc[d]];
          if (frame_n[outSrc[d]]) outLocked[d] <= 1'b0;
        end else begin
          dout[d]     <= 1'b0;
          valido_n[d] <= 1'b1;
          frameo_n[d] <= 1'b1;
          if (grantOut[d]) begin
            outLocked[d] <= 1'b1;
            outSrc[d]    <= grantSrc[d];
          end
        end
      end
    end
  end

`ifdef ROUTER_RR_ARB_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < NPORTS; d++) rrPtr[d] <= '0;
    end else begin
      for (int d = 0; d < NPORTS; d++)
        if (grantOut[d]) rrPtr[d] <= grantSrc[d] + ADDR_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_serial_router_16x16.sv
// ---------------------------------------------------------------------------
// tb_serial_router_16x16
//
// Bench for serial_router_16x16. Stimulus is queued per input as streams of
// (frame_n, valid_n, din) cycles. A packet-level reference model tracks which
// input owns which output and what phase each input is in, and predicts the
// registered outputs; one compare process checks every cycle. Directed
// scenarios add hand-computed payload, length and busy-duration expectations.
// ---------------------------------------------------------------------------
module tb_serial_router_16x16;

  logic        clock;
  logic        reset_n;
  logic [15:0] din, frame_n, valid_n;
  logic [15:0] dout, valido_n, frameo_n, busy_n;

  int checks = 0;
  int errors = 0;

  serial_router_16x16 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .din      (din),
    .frame_n  (frame_n),
    .valid_n  (valid_n),
    .dout     (dout),
    .valido_n (valido_n),
    .frameo_n (frameo_n),
    .busy_n   (busy_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 taking address, 2 forwarding, 3 dropped, 4 waiting end
  int          mPhase [16];
  int          mBits  [16];
  int          mAddr  [16];
  int          mOwner [16];   // input connected to each output, -1 if free
  int          mPtr   [16];
  int          newOwner [16];
  int          reqTo  [16];
  bit          mStarted = 1'b0;
  int          win, cand, start;
  logic [15:0] eDout = '0, eVal = '1, eFrm = '1, eBusy = '1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eDout = '0; eVal = '1; eFrm = '1; eBusy = '1;
      mStarted = 1'b0;
      for (int i = 0; i < 16; i++) begin
        mPhase[i] = 0; mBits[i] = 0; mAddr[i] = 0; mOwner[i] = -1; mPtr[i] = 0;
      end
    end else begin
      for (int d = 0; d < 16; d++) begin
        if (mOwner[d] >= 0) begin
          eDout[d] = din[mOwner[d]];
          eVal[d]  = valid_n[mOwner[d]];
          eFrm[d]  = frame_n[mOwner[d]];
          newOwner[d] = frame_n[mOwner[d]] ? -1 : mOwner[d];
        end else begin
          eDout[d] = 1'b0; eVal[d] = 1'b1; eFrm[d] = 1'b1;
          newOwner[d] = -1;
        end
      end
      for (int s = 0; s < 16; s++) begin
        reqTo[s] = -1;
        if (mPhase[s] == 1 && mBits[s] == 3 && !frame_n[s])
          reqTo[s] = mAddr[s] + (din[s] ? 8 : 0);
      end
      for (int d = 0; d < 16; d++) begin
        if (mOwner[d] < 0) begin
          win = -1;
`ifdef ROUTER_RR_ARB_EN
          start = mPtr[d];
`else
          start = 0;
`endif
          for (int k = 0; k < 16; k++) begin
            cand = (start + k) % 16;
            if (win < 0 && reqTo[cand] == d) win = cand;
          end
          if (win >= 0) begin
            newOwner[d] = win;
            mPtr[d] = (win + 1) % 16;
          end
        end
      end
      for (int s = 0; s < 16; s++) begin
        case (mPhase[s])
          0: if (!frame_n[s]) begin
               if (!mStarted) mPhase[s] = 4;
               else begin mPhase[s] = 1; mAddr[s] = din[s] ? 1 : 0; mBits[s] = 1; end
             end
          1: if (frame_n[s]) mPhase[s] = 0;
             else if (mBits[s] == 3) begin
               mPhase[s] = 3;
               for (int d = 0; d < 16; d++) if (newOwner[d] == s) mPhase[s] = 2;
             end else begin
               if (din[s]) mAddr[s] = mAddr[s] + (1 << mBits[s]);
               mBits[s] = mBits[s] + 1;
             end
          default: if (frame_n[s]) mPhase[s] = 0;
        endcase
        eBusy[s] = (mPhase[s] != 3);
      end
      for (int d = 0; d < 16; d++) mOwner[d] = newOwner[d];
      mStarted = 1'b1;
    end
  end

  // ---------------- compare + per-scenario statistics ----------------
  bit colBits [16][$];
  int valLow [16], frmLow [16], busyLow [16];

  always @(negedge clock) begin
    check("dout",     32'(dout),     32'(eDout));
    check("valido_n", 32'(valido_n), 32'(eVal));
    check("frameo_n", 32'(frameo_n), 32'(eFrm));
    check("busy_n",   32'(busy_n),   32'(eBusy));
    for (int d = 0; d < 16; d++) begin
      if (!valido_n[d]) begin colBits[d].push_back(dout[d]); valLow[d]++; end
      if (!frameo_n[d]) frmLow[d]++;
      if (!busy_n[d])   busyLow[d]++;
    end
  end

  task automatic clearStats();
    for (int d = 0; d < 16; d++) begin
      colBits[d].delete(); valLow[d] = 0; frmLow[d] = 0; busyLow[d] = 0;
    end
  endtask

  function automatic logic [31:0] bitsVal(int d);
    logic [31:0] v = '0;
    for (int i = 0; i < colBits[d].size() && i < 32; i++) v[i] = colBits[d][i];
    return v;
  endfunction

  function automatic int valLowExcept(int a, int b);
    int n = 0;
    for (int d = 0; d < 16; d++) if (d != a && d != b) n += valLow[d];
    return n;
  endfunction

  function automatic int busyTotal();
    int n = 0;
    for (int d = 0; d < 16; d++) n += busyLow[d];
    return n;
  endfunction

  // ---------------- stimulus streams ----------------
  bit qF [16][$];
  bit qV [16][$];
  bit qD [16][$];

  task automatic push(int p, bit f, bit v, bit d);
    qF[p].push_back(f); qV[p].push_back(v); qD[p].push_back(d);
  endtask

  task automatic addIdle(int p, int n);
    for (int i = 0; i < n; i++) push(p, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic addPkt(int p, int dest, int npad, logic [31:0] pay, int plen,
                        int gapAt, int gapLen);
    for (int i = 0; i < 4; i++) push(p, 1'b0, 1'b1, dest[i]);
    for (int i = 0; i < npad; i++) push(p, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < plen; i++) begin
      if (i == gapAt)
        for (int g = 0; g < gapLen; g++) push(p, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      push(p, (i == plen - 1), 1'b0, pay[i]);
    end
  endtask

  function automatic bit anyPending();
    for (int p = 0; p < 16; p++) if (qF[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of every stream, then move to just after the next edge.
  task automatic stepCycle();
    for (int p = 0; p < 16; p++) begin
      if (qF[p].size() > 0) begin
        frame_n[p] = qF[p].pop_front();
        valid_n[p] = qV[p].pop_front();
        din[p]     = qD[p].pop_front();
      end else begin
        frame_n[p] = 1'b1;
        valid_n[p] = 1'b1;
        din[p]     = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic runUntilEmpty(int extra);
    while (anyPending()) stepCycle();
    repeat (extra) stepCycle();
  endtask

  // ---------------- scenarios ----------------
  int mode, nA, dst, np, pl, ga, gl;

  initial begin
    reset_n = 1'b0;
    din = '0; frame_n = '1; valid_n = '1;

    // Reset with random inputs.
    repeat (3) begin
      din = 16'($urandom); frame_n = 16'($urandom); valid_n = 16'($urandom);
      @(posedge clock); #1;
    end
    check("rst_dout",     32'(dout),     32'h0);
    check("rst_valido_n", 32'(valido_n), 32'hFFFF);
    check("rst_frameo_n", 32'(frameo_n), 32'hFFFF);
    check("rst_busy_n",   32'(busy_n),   32'hFFFF);
    frame_n = '1; valid_n = '1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) stepCycle();
    check("idle_frameo_n", 32'(frameo_n), 32'hFFFF);
    check("idle_valido_n", 32'(valido_n), 32'hFFFF);

    // Single packet 3 -> 5.
    clearStats();
    addPkt(3, 5, 5, 32'hA5, 8, -1, 0);
    runUntilEmpty(3);
    check("p1_payload", bitsVal(5), 32'hA5);
    check("p1_valid_cycles", valLow[5], 8);
    check("p1_frame_cycles", frmLow[5], 12);
    check("p1_other_outputs", valLowExcept(5, 5), 0);
    check("p1_busy", busyTotal(), 0);

    // Concurrent 0 -> 15 and 15 -> 0.
    clearStats();
    addPkt(0, 15, 3, 32'h3C, 8, -1, 0);
    addPkt(15, 0, 3, 32'hC3, 8, -1, 0);
    runUntilEmpty(3);
    check("cc_out15", bitsVal(15), 32'h3C);
    check("cc_out0",  bitsVal(0),  32'hC3);
    check("cc_crosstalk", valLowExcept(0, 15), 0);

    // Valid gap: 2 idle qualifier cycles after payload bit 3.
    clearStats();
    addPkt(9, 12, 2, 32'h5A, 8, 4, 2);
    runUntilEmpty(3);
    check("gap_payload", bitsVal(12), 32'h5A);
    check("gap_valid_cycles", valLow[12], 8);
    check("gap_frame_cycles", frmLow[12], 11);

    // Contention: inputs 2 and 7 to output 4, twice.
    clearStats();
    addPkt(2, 4, 2, 32'h96, 8, -1, 0);
    addPkt(7, 4, 2, 32'h69, 8, -1, 0);
    runUntilEmpty(3);
    check("ct1_payload", bitsVal(4), 32'h96);
    check("ct1_valid_cycles", valLow[4], 8);
    check("ct1_busy7", busyLow[7], 10);
    check("ct1_busy2", busyLow[2], 0);
    clearStats();
    addPkt(2, 4, 2, 32'h96, 8, -1, 0);
    addPkt(7, 4, 2, 32'h69, 8, -1, 0);
    runUntilEmpty(3);
`ifdef ROUTER_RR_ARB_EN
    check("ct2_payload", bitsVal(4), 32'h69);
    check("ct2_busy2", busyLow[2], 10);
`else
    check("ct2_payload", bitsVal(4), 32'h96);
    check("ct2_busy7", busyLow[7], 10);
`endif

    // Reset during forwarding of 1 -> 6.
    addPkt(1, 6, 3, 32'hDEADBEEF, 16, -1, 0);
    repeat (10) stepCycle();
    reset_n = 1'b0;
    #1;
    check("mrst_dout",     32'(dout),     32'h0);
    check("mrst_valido_n", 32'(valido_n), 32'hFFFF);
    check("mrst_frameo_n", 32'(frameo_n), 32'hFFFF);
    check("mrst_busy_n",   32'(busy_n),   32'hFFFF);
    clearStats();
    repeat (2) stepCycle();
    reset_n = 1'b1;
    runUntilEmpty(3);
    check("mrst_no_frame", frmLow[6], 0);
    check("mrst_no_valid", valLowExcept(-1, -1), 0);
    clearStats();
    addPkt(1, 6, 1, 32'h7E, 8, -1, 0);
    runUntilEmpty(3);
    check("mrst_fresh", bitsVal(6), 32'h7E);

    // Randomized traffic, including contention, aborts and short addresses.
    for (int r = 0; r < 40; r++) begin
      clearStats();
      for (int p = 0; p < 16; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          addIdle(p, $urandom_range(0, 3));
          mode = $urandom_range(0, 9);
          dst  = $urandom_range(0, 15);
          np   = $urandom_range(0, 3);
          if (mode == 0) begin
            nA = $urandom_range(1, 3);
            for (int i = 0; i < nA; i++) push(p, 1'b0, 1'b1, dst[i]);
            addIdle(p, 1);
          end else if (mode == 1) begin
            addPkt(p, dst, np, 32'h0, 0, -1, 0);
            addIdle(p, 1);
          end else begin
            pl = $urandom_range(1, 10);
            ga = $urandom_range(0, 12);
            gl = $urandom_range(1, 2);
            addPkt(p, dst, np, $urandom, pl, ga, gl);
          end
        end
      end
      runUntilEmpty(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_router_16x16.md
Name: serial_router_16x16

Overview:
- 16-input, 16-output bit-serial packet switch with a crossbar.
- Each input port receives a packet made of: a 4-bit destination address, padding cycles, then a variable-length payload.
- The block connects the input to the addressed output and forwards payload bits with one cycle of latency.
- It is the DUT core of the router verification environment; all ports are per-port 16-bit vectors.

Parameters:
- NPORTS, 16, number of input/output ports; fixed at 16 because the address is 4 bits.
- ADDR_BITS, 4, destination address width, sent serially LSB first.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  16  serial data per input port.
- frame_n  input  16  active-low packet frame per input; low from address bit 0 through the last payload bit; rises on the cycle of the last payload bit.
- valid_n  input  16  active-low payload-bit qualifier per input.
- dout  output  16  serial data per output port.
- valido_n  output  16  active-low payload-bit qualifier per output.
- frameo_n  output  16  active-low packet frame per output.
- busy_n  output  16  active-low per input port; low while that input's packet is being dropped due to contention.

Behaviour:
- Reset (asynchronous): dout=0, valido_n=16'hFFFF, frameo_n=16'hFFFF, busy_n=16'hFFFF. All connections are cleared and all input FSMs return to IDLE.
- Per-input FSM states: IDLE, ADDR, XFER, DROP, WAITEND.
- IDLE: when frame_n[s] is sampled low, capture din[s] as address bit0 and go to ADDR.
- ADDR: capture bits 1..3 on the next three cycles, LSB first. valid_n is ignored during address capture.
- Arbitration happens at the edge that samples address bit3:
  - If the output is free and this input wins, go to XFER and lock the output to source s.
  - Otherwise go to DROP and drive busy_n[s] low from the next cycle.
- Contention rule: if several inputs finish their address in the same cycle for the same free output, the lowest input index wins (fixed priority). An output already locked is never preempted.
- XFER: each cycle the output registers copy the source:
  - dout[d] <= din[s], valido_n[d] <= valid_n[s], frameo_n[d] <= frame_n[s].
  - Latency is exactly one clock. frameo_n[d] therefore falls two cycles after the bit3 cycle.
  - Padding cycles (frame_n low, valid_n high) appear as frameo_n low with valido_n high.
  - Gaps in valid_n are mirrored on valido_n.
- End of packet: when frame_n[s] is sampled high, the output is released, frameo_n[d] goes high that edge, and the input returns to IDLE. A new packet on that output may then be granted.
- Abort: if frame_n rises before any payload bit, the same release happens; no valido_n pulse is produced.
- While an output is unlocked it holds: dout[d]=0, valido_n[d]=1, frameo_n[d]=1.
- DROP: input bits are discarded. busy_n[s] stays low until frame_n[s] is sampled high, then goes high and the input returns to IDLE.
- Reset mid-packet: after reset is released, an input whose frame_n is still low goes to WAITEND. It ignores input until frame_n is sampled high, then returns to IDLE. No partial packet is forwarded.
- A frame_n high pulse while in ADDR returns the input to IDLE with no request made.
- Independent input/output pairs operate concurrently with no interaction.

Optional Feature:
- Macro: ROUTER_RR_ARB_EN.
- Defined: each output keeps a 4-bit round-robin pointer. On simultaneous requests, the winner is the first requesting input at or after the pointer. The pointer moves to winner+1 on each grant. Pointers reset to 0.
- Undefined: fixed priority, lowest input index wins; no pointer logic is generated.

Test Plan:
- Reset: assert reset_n=0 with random inputs -> all outputs at reset values; release reset with frame_n=16'hFFFF -> outputs stay idle.
- Single packet, input 3 -> output 5:
  - Stimulus: address 4'b0101 LSB first, 5 padding cycles, payload 8'hA5 LSB first, frame_n[3] rising on the last bit.
  - Required: dout[5] shows the bits one cycle later with valido_n[5] low for 8 cycles; frameo_n[5] is low and rises one cycle after frame_n[3]; all other outputs idle; busy_n all high.
- Concurrent traffic: input 0 -> output 15 and input 15 -> output 0, in the same cycles -> both payloads delivered intact with no crosstalk.
- Contention: inputs 2 and 7 both address output 4 in the same cycle -> input 2's payload appears on output 4; busy_n[7] goes low the cycle after bit3 and returns high after frame_n[7] rises; input 7's data never appears. With ROUTER_RR_ARB_EN defined, repeating the collision grants input 7 second.
- Valid gaps: payload with valid_n high for 2 mid-packet cycles -> valido_n[d] high for the matching 2 cycles, one cycle delayed, with frameo_n[d] kept low.
- Reset mid-packet: assert reset_n during XFER -> outputs idle immediately; after release with frame_n still low, no bits are forwarded until a fresh packet starts.
